bcd_frame_packer: RTL and testbench

//  Downstream stage of the Excess-3-to-BCD converter. Takes converted BCD digits one at a time
//  on a valid/ready handshake and packs NUM_DIGITS of them (MSD first) into one packed-BCD word.

---
 rtl/bcd_frame_packer.sv | 175 +++++++++++++++++
 tb/tb_bcd_frame_packer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_frame_packer.sv
// -----------------------------------------------------------------------------
// bcd_frame_packer
//
// Purpose:
//   Collects BCD digits arriving one per accepted handshake and packs
//   NUM_DIGITS of them into one packed-BCD frame. The first digit received
//   ends up in the top nibble. A frame is flagged if any digit is above 9.
//   A shift register builds the next frame while a separate output register
//   holds the current frame until the consumer takes it.
//
// Ports:
//   clk        in   single clock, all state on the rising edge
//   rst        in   synchronous active-high reset; takes priority over clr
//   clr        in   synchronous clear of the partial frame (ACC state only)
//   din        in   [3:0] BCD digit, MSB first
//   din_valid  in   din qualifier
//   din_ready  out  stage can accept din this cycle (depends only on state/clr)
//   dig_cnt    out  digits currently held in the assembly register
//   out_bcd    out  [4*NUM_DIGITS-1:0] packed frame
//   out_err    out  frame contained at least one digit > 9
//   out_valid  out  out_bcd/out_err (and out_bin) valid
//   out_ready  in   consumer accepts the frame
//   out_bin    out  [BIN_W-1:0] binary value of the frame (BCD_PACK_BIN_EN only)
//
// Build option:
//   BCD_PACK_BIN_EN  when defined, adds parameter BIN_W, port out_bin and a
//                    binary accumulator (acc*10 + digit, modulo 2^BIN_W).
// -----------------------------------------------------------------------------
module bcd_frame_packer #(
    parameter int NUM_DIGITS = 4
`ifdef BCD_PACK_BIN_EN
    ,
    parameter int BIN_W      = 14
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    input  logic [3:0]                    din,
    input  logic                          din_valid,
    output logic                          din_ready,
    output logic [$clog2(NUM_DIGITS+1)-1:0] dig_cnt,
    output logic [4*NUM_DIGITS-1:0]       out_bcd,
    output logic                          out_err,
    output logic                          out_valid,
    input  logic                          out_ready
`ifdef BCD_PACK_BIN_EN
    ,
    output logic [BIN_W-1:0]              out_bin
`endif
);

    localparam int FRAME_W = 4 * NUM_DIGITS;
    localparam int CNT_W   = $clog2(NUM_DIGITS + 1);

    localparam logic [0:0] ST_ACC   = 1'b0;
    localparam logic [0:0] ST_STALL = 1'b1;

    logic [0:0]         r_state;
    logic [CNT_W-1:0]   r_dig_cnt;
    logic [FRAME_W-1:0] r_asm;
    logic               r_err_acc;
    logic [FRAME_W-1:0] r_out_bcd;
    logic               r_out_err;
    logic               r_out_valid;

    logic               w_accept;
    logic               w_last;
    logic               w_out_free;
    logic [FRAME_W-1:0] w_asm_next;
    logic               w_err_next;

    // Ready never looks at din_valid, so upstream can build valid from ready.
    assign din_ready  = (r_state == ST_ACC) && !clr;
    assign w_accept   = din_valid && din_ready;
    assign w_last     = w_accept && (r_dig_cnt == CNT_W'(NUM_DIGITS - 1));
    assign w_out_free = !r_out_valid || out_ready;

    // Non-decimal digits are shifted in unchanged; only the flag records them.
    assign w_asm_next = {r_asm[FRAME_W-5:0], din};
    assign w_err_next = r_err_acc || (din > 4'd9);

`ifdef BCD_PACK_BIN_EN
    logic [BIN_W-1:0] r_bin_acc;
    logic [BIN_W-1:0] r_out_bin;
    logic [BIN_W-1:0] w_bin_next;

    // Wraps modulo 2^BIN_W; raw value of an illegal digit is added as-is.
    assign w_bin_next = (r_bin_acc * BIN_W'(10)) + BIN_W'(din);
    assign out_bin    = r_out_bin;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_ACC;
            r_dig_cnt   <= '0;
            r_asm       <= '0;
            r_err_acc   <= 1'b0;
            r_out_bcd   <= '0;
            r_out_err   <= 1'b0;
            r_out_valid <= 1'b0;
`ifdef BCD_PACK_BIN_EN
            r_bin_acc   <= '0;
            r_out_bin   <= '0;
`endif
        end else begin
            // Consumed frame goes away unless a new one overwrites it below.
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                ST_ACC: begin
                    if (clr) begin
                        r_dig_cnt <= '0;
                        r_asm     <= '0;
                        r_err_acc <= 1'b0;
`ifdef BCD_PACK_BIN_EN
                        r_bin_acc <= '0;
`endif
                    end else if (w_last && w_out_free) begin
                        // Completed frame goes straight to the output register.
                        r_out_bcd   <= w_asm_next;
                        r_out_err   <= w_err_next;
                        r_out_valid <= 1'b1;
                        r_dig_cnt   <= '0;
                        r_asm       <= '0;
                        r_err_acc   <= 1'b0;
`ifdef BCD_PACK_BIN_EN
                        r_out_bin   <= w_bin_next;
                        r_bin_acc   <= '0;
`endif
                    end else if (w_accept) begin
                        r_asm     <= w_asm_next;
                        r_err_acc <= w_err_next;
                        r_dig_cnt <= r_dig_cnt + CNT_W'(1);
`ifdef BCD_PACK_BIN_EN
                        r_bin_acc <= w_bin_next;
`endif
                        // Output still occupied: park the full frame in asm.
                        if (w_last) begin
                            r_state <= ST_STALL;
                        end
                    end
                end

                ST_STALL: begin
                    if (out_ready) begin
                        r_out_bcd   <= r_asm;
                        r_out_err   <= r_err_acc;
                        r_out_valid <= 1'b1;
                        r_dig_cnt   <= '0;
                        r_asm       <= '0;
                        r_err_acc   <= 1'b0;
`ifdef BCD_PACK_BIN_EN
                        r_out_bin   <= r_bin_acc;
                        r_bin_acc   <= '0;
`endif
                        r_state     <= ST_ACC;
                    end
                end

                default: begin
                    r_state <= ST_ACC;
                end
            endcase
        end
    end

    assign dig_cnt   = r_dig_cnt;
    assign out_bcd   = r_out_bcd;
    assign out_err   = r_out_err;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_bcd_frame_packer.sv
module tb_bcd_frame_packer;

    localparam int ND    = 4;
    localparam int BIN_W = 14;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic [3:0]  din = 4'd0;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic [2:0]  dig_cnt;
    logic [15:0] out_bcd;
    logic        out_err;
    logic        out_valid;
    logic        out_ready = 1'b0;
`ifdef BCD_PACK_BIN_EN
    logic [BIN_W-1:0] out_bin;
`endif

    bcd_frame_packer #(
        .NUM_DIGITS(ND)
`ifdef BCD_PACK_BIN_EN
        , .BIN_W(BIN_W)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .clr(clr),
        .din(din),
        .din_valid(din_valid),
        .din_ready(din_ready),
        .dig_cnt(dig_cnt),
        .out_bcd(out_bcd),
        .out_err(out_err),
        .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef BCD_PACK_BIN_EN
        , .out_bin(out_bin)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]      bcd;
        logic             err;
        logic [BIN_W-1:0] bin;
    } exp_t;

    typedef struct {
        logic [3:0][3:0] d;     // d[3] is sent first
        logic [15:0]     bcd;
        logic            err;
    } vec_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Expected binary value of a frame, computed digit by digit.
    function automatic logic [BIN_W-1:0] bin_of(input logic [3:0][3:0] d);
        logic [BIN_W-1:0] acc = '0;
        for (int k = 3; k >= 0; k--) acc = acc * BIN_W'(10) + BIN_W'(d[k]);
        return acc;
    endfunction

    task automatic push_exp(input logic [3:0][3:0] d, input logic [15:0] bcd, input logic err);
        exp_t e;
        e.bcd = bcd;
        e.err = err;
        e.bin = bin_of(d);
        sb.push_back(e);
    endtask

    // Hold din_valid until the digit is accepted; returns at posedge+1.
    task automatic send(input logic [3:0] d);
        int waited = 0;
        din = d;
        din_valid = 1'b1;
        @(negedge clk);
        while (!din_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!din_ready) begin
            n_checks++;
            $display("FAIL send_timeout: din_ready got 0 expected 1");
        end
        @(posedge clk);
        #1;
        din_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [3:0][3:0] d);
        for (int k = 3; k >= 0; k--) send(d[k]);
    endtask

    // Scoreboard: compare each frame at the cycle it is handed over.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_frame: got %0h expected none", out_bcd);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("frame_bcd", 32'(out_bcd), 32'(e.bcd));
                check("frame_err", 32'(out_err), 32'(e.err));
`ifdef BCD_PACK_BIN_EN
                check("frame_bin", 32'(out_bin), 32'(e.bin));
`endif
                $display("frame out_bcd=%04h out_err=%0d", out_bcd, out_err);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    vec_t vecs[6];

    initial begin
        vecs[0] = '{d: {4'h1, 4'h2, 4'h3, 4'h4}, bcd: 16'h1234, err: 1'b0};
        vecs[1] = '{d: {4'h9, 4'hC, 4'h0, 4'h1}, bcd: 16'h9C01, err: 1'b1};
        vecs[2] = '{d: {4'h0, 4'h0, 4'h0, 4'h7}, bcd: 16'h0007, err: 1'b0};
        vecs[3] = '{d: {4'hF, 4'hF, 4'hF, 4'hF}, bcd: 16'hFFFF, err: 1'b1};
        vecs[4] = '{d: {4'h9, 4'h9, 4'h9, 4'h9}, bcd: 16'h9999, err: 1'b0};
        vecs[5] = '{d: {4'hA, 4'h0, 4'h0, 4'h0}, bcd: 16'hA000, err: 1'b1};

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_bcd",   32'(out_bcd),   32'd0);
        check("rst_out_err",   32'(out_err),   32'd0);
        check("rst_dig_cnt",   32'(dig_cnt),   32'd0);
        check("rst_din_ready", 32'(din_ready), 32'd1);
`ifdef BCD_PACK_BIN_EN
        check("rst_out_bin",   32'(out_bin),   32'd0);
`endif
        @(posedge clk);
        #1;

        // Table-driven frames with consumer always ready
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push_exp(vecs[i].d, vecs[i].bcd, vecs[i].err);
            send_frame(vecs[i].d);
            if (i == 0) begin
                check("latency_out_valid", 32'(out_valid), 32'd1);
                check("latency_dig_cnt",   32'(dig_cnt),   32'd0);
            end
        end
        repeat (2) @(posedge clk);
        #1;
        check("idle_out_valid", 32'(out_valid), 32'd0);

        // Stall: two frames with consumer blocked
        out_ready = 1'b0;
        push_exp({4'h1, 4'h2, 4'h3, 4'h4}, 16'h1234, 1'b0);
        send_frame({4'h1, 4'h2, 4'h3, 4'h4});
        push_exp({4'h5, 4'h6, 4'h7, 4'h8}, 16'h5678, 1'b0);
        send_frame({4'h5, 4'h6, 4'h7, 4'h8});
        check("stall_din_ready", 32'(din_ready), 32'd0);
        check("stall_dig_cnt",   32'(dig_cnt),   32'd4);
        repeat (3) @(posedge clk);
        #1;
        check("stall_hold_bcd",   32'(out_bcd),   32'h1234);
        check("stall_hold_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("b2b_out_valid", 32'(out_valid), 32'd1);
        check("b2b_out_bcd",   32'(out_bcd),   32'h5678);
        check("b2b_din_ready", 32'(din_ready), 32'd1);
        check("b2b_dig_cnt",   32'(dig_cnt),   32'd0);
        repeat (2) @(posedge clk);
        #1;

        // clr drops the partial frame and the digit offered alongside it
        send(4'h3);
        send(4'h4);
        check("pre_clr_dig_cnt", 32'(dig_cnt), 32'd2);
        din = 4'h5;
        din_valid = 1'b1;
        clr = 1'b1;
        #1;
        check("clr_din_ready", 32'(din_ready), 32'd0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        din_valid = 1'b0;
        check("clr_dig_cnt", 32'(dig_cnt), 32'd0);
        push_exp({4'h6, 4'h7, 4'h8, 4'h9}, 16'h6789, 1'b0);
        send_frame({4'h6, 4'h7, 4'h8, 4'h9});
        repeat (2) @(posedge clk);
        #1;

        // rst while stalled with an output frame held
        out_ready = 1'b0;
        send_frame({4'h1, 4'h1, 4'h1, 4'h1});
        send_frame({4'h2, 4'h2, 4'h2, 4'h2});
        check("pre_rst_din_ready", 32'(din_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_stall_out_valid", 32'(out_valid), 32'd0);
        check("rst_stall_dig_cnt",   32'(dig_cnt),   32'd0);
        check("rst_stall_din_ready", 32'(din_ready), 32'd1);
        check("rst_stall_out_bcd",   32'(out_bcd),   32'd0);

        // Clean frame after the reset
        out_ready = 1'b1;
        push_exp({4'h4, 4'h3, 4'h2, 4'h1}, 16'h4321, 1'b0);
        send_frame({4'h4, 4'h3, 4'h2, 4'h1});
        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
